// File: rtl/stat_pkg.sv
// Shared definitions for the pipelined Stat mixing network: cell types,
// fan-in offsets and the 3-input cell evaluator.
package stat_pkg;

    typedef enum logic [1:0] {
        CELL_XOR3  = 2'd0,
        CELL_NAND3 = 2'd1,
        CELL_NOR3  = 2'd2,
        CELL_XNOR3 = 2'd3
    } cell_t;

    localparam int OFF_B = 1;
    localparam int OFF_C = 3;

    function automatic logic cell_eval(cell_t t, logic a, logic b, logic c);
        logic r;
        r = 1'b0;
        case (t)
            CELL_XOR3:  r = a ^ b ^ c;
            CELL_NAND3: r = ~(a & b & c);
            CELL_NOR3:  r = ~(a | b | c);
            CELL_XNOR3: r = ~(a ^ b ^ c);
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stat_mix_layer.sv
// One combinational mixing layer f_s; the cell type rotates with bit index
// and layer number so every layer sees a different cell pattern.
module stat_mix_layer
    import stat_pkg::*;
#(
    parameter int W     = 8,
    parameter int STAGE = 0
) (
    input  logic [W-1:0] x_i,
    input  logic         mode_i,
    output logic [W-1:0] y_o
);

    logic [W-1:0] mixed;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            localparam cell_t CT = cell_t'(2'((gi + STAGE) % 4));
            assign mixed[gi] = cell_eval(CT, x_i[gi], x_i[(gi + OFF_B) % W],
                                         x_i[(gi + OFF_C) % W]);
        end
    endgenerate

    // Pass-through words travel unmodified through every layer.
    assign y_o = mode_i ? x_i : mixed;

endmodule

// File: rtl/stat_pipe_bench.sv
// DEPTH-stage registered mixing pipeline with valid/ready at both ends and
// per-word output-change detection feeding a saturating change counter.
module stat_pipe_bench
    import stat_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_changed,
    output logic [CNT_W-1:0] chg_cnt
);

    // The last stage's mode is never consumed, so only DEPTH-1 mode bits exist.
    localparam int MW = (DEPTH > 1) ? DEPTH - 1 : 1;

    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [W-1:0]     lay_in [DEPTH];
    logic [DEPTH-1:0] lay_mode;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [MW-1:0]    mode_q;

    logic             adv;
    logic             deliver;
    logic [W-1:0]     last_q, last_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign lay_in[gi]   = in_data;
                assign lay_mode[gi] = mode;
                assign valid_d[gi]  = in_valid;
            end else begin : g_body
                assign lay_in[gi]   = data_q[gi-1];
                assign lay_mode[gi] = mode_q[gi-1];
                assign valid_d[gi]  = valid_q[gi-1];
            end

            stat_mix_layer #(
                .W     (W),
                .STAGE (gi)
            ) u_layer (
                .x_i    (lay_in[gi]),
                .mode_i (lay_mode[gi]),
                .y_o    (data_d[gi])
            );
        end
    endgenerate

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign adv       = !valid_q[DEPTH-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign deliver   = valid_q[DEPTH-1] & out_ready;

    assign out_changed = valid_q[DEPTH-1] & (!seen_q | (data_q[DEPTH-1] != last_q));
    assign chg_cnt     = chg_cnt_q;

    always_comb begin
        last_d    = last_q;
        seen_d    = seen_q;
        chg_cnt_d = chg_cnt_q;
        if (deliver) begin
            last_d = data_q[DEPTH-1];
            seen_d = 1'b1;
            if (out_changed && (chg_cnt_q != {CNT_W{1'b1}})) begin
                chg_cnt_d = chg_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            last_q    <= '0;
            seen_q    <= 1'b0;
            chg_cnt_q <= '0;
        end else begin
            last_q    <= last_d;
            seen_q    <= seen_d;
            chg_cnt_q <= chg_cnt_d;
            if (adv) begin
                valid_q <= valid_d;
                for (int s = 0; s < DEPTH; s++) begin
                    data_q[s] <= data_d[s];
                end
                for (int s = 0; s < DEPTH - 1; s++) begin
                    mode_q[s] <= lay_mode[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_stat_pipe_bench.sv
// Scoreboard bench: two instances (DEPTH=1/CNT_W=8 and DEPTH=2/CNT_W=2)
// share stimulus; expected words are queued at acceptance and popped on delivery.
module tb_stat_pipe_bench;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         drv_valid;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         mode;
    logic         out_ready;

    logic         a_in_ready, b_in_ready;
    logic         a_out_valid, b_out_valid;
    logic         a_out_changed, b_out_changed;
    logic [W-1:0] a_out_data, b_out_data;
    logic [7:0]   a_cnt;
    logic [1:0]   b_cnt;

    // Both instances accept the same words, so a word is only offered when both are ready.
    assign in_valid = drv_valid & a_in_ready & b_in_ready;

    stat_pipe_bench #(.W(W), .DEPTH(1), .CNT_W(8)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (a_in_ready),
        .in_data     (in_data),
        .mode        (mode),
        .out_valid   (a_out_valid),
        .out_ready   (out_ready),
        .out_data    (a_out_data),
        .out_changed (a_out_changed),
        .chg_cnt     (a_cnt)
    );

    stat_pipe_bench #(.W(W), .DEPTH(2), .CNT_W(2)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (b_in_ready),
        .in_data     (in_data),
        .mode        (mode),
        .out_valid   (b_out_valid),
        .out_ready   (out_ready),
        .out_data    (b_out_data),
        .out_changed (b_out_changed),
        .chg_cnt     (b_cnt)
    );

    logic         ov_w  [2];
    logic         rdy_w [2];
    logic         ch_w  [2];
    logic [W-1:0] od_w  [2];
    logic [7:0]   cnt_w [2];

    assign ov_w[0]  = a_out_valid;
    assign ov_w[1]  = b_out_valid;
    assign rdy_w[0] = a_in_ready;
    assign rdy_w[1] = b_in_ready;
    assign ch_w[0]  = a_out_changed;
    assign ch_w[1]  = b_out_changed;
    assign od_w[0]  = a_out_data;
    assign od_w[1]  = b_out_data;
    assign cnt_w[0] = a_cnt;
    assign cnt_w[1] = {6'b0, b_cnt};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_layer(input logic [W-1:0] x, input int s);
        logic [W-1:0] y;
        logic a, b, c;
        y = '0;
        for (int i = 0; i < W; i++) begin
            a = x[i];
            b = x[(i + 1) % W];
            c = x[(i + 3) % W];
            case ((i + s) % 4)
                0:       y[i] = a ^ b ^ c;
                1:       y[i] = !(a && b && c);
                2:       y[i] = !(a || b || c);
                default: y[i] = !(a ^ b ^ c);
            endcase
        end
        return y;
    endfunction

    function automatic logic [W-1:0] ref_word(input logic [W-1:0] x, input int depth, input logic m);
        logic [W-1:0] v;
        v = x;
        if (!m) begin
            for (int s = 0; s < depth; s++) v = ref_layer(v, s);
        end
        return v;
    endfunction

    logic [W-1:0] exp_q [2][$];
    int           dep_m  [2] = '{1, 2};
    int           max_m  [2] = '{255, 3};
    int           cnt_m  [2] = '{0, 0};
    int           pops   [2] = '{0, 0};
    logic [W-1:0] last_m [2];
    logic         first_m[2];
    logic [W-1:0] mon_e;
    logic         mon_c;

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                exp_q[d].delete();
                cnt_m[d]   = 0;
                last_m[d]  = '0;
                first_m[d] = 1'b1;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d chg_cnt", d), 32'(cnt_w[d]), 32'(cnt_m[d]));
                if (ov_w[d] && out_ready) begin
                    if (exp_q[d].size() == 0) begin
                        chk($sformatf("dut%0d spurious out_valid", d), 32'(ov_w[d]), 32'd0);
                    end else begin
                        mon_e = exp_q[d].pop_front();
                        mon_c = first_m[d] || (mon_e != last_m[d]);
                        chk($sformatf("dut%0d out_data", d), 32'(od_w[d]), 32'(mon_e));
                        chk($sformatf("dut%0d out_changed", d), 32'(ch_w[d]), 32'(mon_c));
                        $display("dut%0d deliver data=%02h changed=%0b", d, od_w[d], ch_w[d]);
                        last_m[d]  = mon_e;
                        first_m[d] = 1'b0;
                        if (mon_c && cnt_m[d] < max_m[d]) cnt_m[d]++;
                        pops[d]++;
                    end
                end
                if (in_valid && rdy_w[d]) exp_q[d].push_back(ref_word(in_data, dep_m[d], mode));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        drv_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
            step();
        end
        chk("drain dut0", 32'(exp_q[0].size()), 32'd0);
        chk("drain dut1", 32'(exp_q[1].size()), 32'd0);
    endtask

    logic [W-1:0] t2_in  [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [W-1:0] t2_out [3] = '{8'h11, 8'h11, 8'hEE};
    logic         t2_chg [3] = '{1'b1, 1'b0, 1'b1};
    logic [W-1:0] t4_in  [4] = '{8'h3C, 8'hC3, 8'h5A, 8'h96};
    logic [W-1:0] snap_a, snap_b;
    int           pops_a0, pops_b0;

    initial begin
        rst = 1'b1;
        drv_valid = 1'b0;
        in_data = '0;
        mode = 1'b0;
        out_ready = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst out_valid a", 32'(a_out_valid), 32'd0);
        chk("rst out_valid b", 32'(b_out_valid), 32'd0);
        chk("rst in_ready a", 32'(a_in_ready), 32'd1);
        chk("rst chg_cnt a", 32'(a_cnt), 32'd0);

        // Single mix word 0x00
        step();
        drv_valid = 1'b1; in_data = 8'h00; mode = 1'b0;
        step();
        drv_valid = 1'b0;
        @(negedge clk);
        chk("t1 valid a", 32'(a_out_valid), 32'd1);
        chk("t1 data a", 32'(a_out_data), 32'hEE);
        chk("t1 changed a", 32'(a_out_changed), 32'd1);
        chk("t1 valid b early", 32'(b_out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t1 cnt a", 32'(a_cnt), 32'd1);
        step();
        drain();

        // Stream FF, FF, 00
        step();
        do_reset();
        drv_valid = 1'b1; mode = 1'b0; in_data = t2_in[0];
        step();
        for (int k = 0; k < 3; k++) begin
            if (k < 2) in_data = t2_in[k+1];
            else drv_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("t2 data[%0d]", k), 32'(a_out_data), 32'(t2_out[k]));
            chk($sformatf("t2 changed[%0d]", k), 32'(a_out_changed), 32'(t2_chg[k]));
            step();
        end
        @(negedge clk);
        chk("t2 cnt a", 32'(a_cnt), 32'd2);
        step();
        drain();

        // Pass-through latency
        step();
        drv_valid = 1'b1; in_data = 8'hA5; mode = 1'b1;
        step();
        drv_valid = 1'b0;
        @(negedge clk);
        chk("t3 valid b 1cyc", 32'(b_out_valid), 32'd0);
        chk("t3 data a", 32'(a_out_data), 32'hA5);
        step();
        @(negedge clk);
        chk("t3 valid b 2cyc", 32'(b_out_valid), 32'd1);
        chk("t3 data b", 32'(b_out_data), 32'hA5);
        step();
        mode = 1'b0;
        drain();

        // Mid-stream stall of 3 cycles
        step();
        pops_a0 = pops[0];
        pops_b0 = pops[1];
        drv_valid = 1'b1; in_data = t4_in[0];
        step();
        in_data = t4_in[1];
        step();
        in_data = t4_in[2];
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                snap_a = a_out_data;
                snap_b = b_out_data;
            end
            chk("t4 stall in_ready a", 32'(a_in_ready), 32'd0);
            chk("t4 stall in_ready b", 32'(b_in_ready), 32'd0);
            chk("t4 stall valid b", 32'(b_out_valid), 32'd1);
            chk("t4 stall hold a", 32'(a_out_data), 32'(snap_a));
            chk("t4 stall hold b", 32'(b_out_data), 32'(snap_b));
            step();
        end
        out_ready = 1'b1;
        step();
        in_data = t4_in[3];
        step();
        drain();
        chk("t4 delivered a", 32'(pops[0] - pops_a0), 32'd4);
        chk("t4 delivered b", 32'(pops[1] - pops_b0), 32'd4);

        // Counter saturation with alternating words
        step();
        do_reset();
        mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drv_valid = 1'b1;
            in_data = (k % 2 == 1) ? 8'hFF : 8'h00;
            step();
        end
        drain();
        chk("t5 sat cnt b", 32'(b_cnt), 32'd3);
        chk("t5 cnt a", 32'(a_cnt), 32'd5);

        // Reset with two words in flight
        step();
        drv_valid = 1'b1; in_data = 8'h12;
        step();
        in_data = 8'h34;
        step();
        drv_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6 valid a", 32'(a_out_valid), 32'd0);
        chk("t6 valid b", 32'(b_out_valid), 32'd0);
        chk("t6 cnt a", 32'(a_cnt), 32'd0);
        chk("t6 cnt b", 32'(b_cnt), 32'd0);
        step();
        drv_valid = 1'b1; in_data = 8'h00; mode = 1'b1;
        step();
        drv_valid = 1'b0;
        @(negedge clk);
        chk("t6 first changed a", 32'(a_out_changed), 32'd1);
        step();
        @(negedge clk);
        chk("t6 first changed b", 32'(b_out_changed), 32'd1);
        step();
        mode = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
